platform_motion_controller: RTL and testbench

- Sits directly downstream of the platform object ROM reader.
- Accepts one platform descriptor per load handshake and animates that platform's position on every movement tick.
- Applies the platform's destroy rule and presents live geometry (pos/size/active) to the renderer and collision logic.
- Handles one platform slot; a new load replaces the current platform.

---
 rtl/platform_motion_controller.sv | 215 +++++++++++++++++++++
 tb/tb_platform_motion_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_motion_controller.sv
// platform_motion_controller
//   Holds one platform slot fed by the platform object ROM reader. A load
//   handshake latches a descriptor. The platform then runs: it moves on
//   move_tick, clamped to the screen, and is removed by its destroy rule.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   sync_platform_position     active-low load request from the ROM reader
//   movement_direction/speed   motion descriptor (speed in pixels per move_tick)
//   pos_x_in/pos_y_in/w_in/h_in start geometry
//   destroy_time/destroy_trigger lifetime and destroy rule
//   move_tick/time_tick        one-cycle frame / game-time pulses
//   player_contact             level, player standing on platform
//   update_platform_position   one-cycle load acknowledge
//   active, pos_x, pos_y, w, h live geometry for renderer/collision
//   destroyed                  one-cycle pulse when an active platform is removed
module platform_motion_controller #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_platform_position,
  input  logic [2:0] movement_direction,
  input  logic [4:0] speed,
  input  logic [9:0] pos_x_in,
  input  logic [9:0] pos_y_in,
  input  logic [9:0] w_in,
  input  logic [9:0] h_in,
  input  logic [7:0] destroy_time,
  input  logic [1:0] destroy_trigger,
  input  logic       move_tick,
  input  logic       time_tick,
  input  logic       player_contact,
  output logic       update_platform_position,
  output logic       active,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [9:0] w,
  output logic [9:0] h,
  output logic       destroyed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t     r_state;
  logic [2:0] r_dir;
  logic [4:0] r_speed;
  logic [9:0] r_x_in;
  logic [9:0] r_y_in;
  logic [9:0] r_w_in;
  logic [9:0] r_h_in;
  logic [1:0] r_trig;
  logic [7:0] r_count;
  logic       r_contact;

  logic        w_up, w_down, w_left, w_right;
  logic [10:0] w_lim_x, w_lim_y;
  logic [10:0] w_sum_x, w_sum_y;
  logic [9:0]  w_nx, w_ny;
  logic        w_hit_x, w_hit_y;
  logic        w_timed_en;
  logic        w_time_destroy;
  logic        w_bnd_destroy;

  always_comb begin
    w_up    = 1'b0;
    w_down  = 1'b0;
    w_left  = 1'b0;
    w_right = 1'b0;
    case (r_dir)
      3'd1: w_up = 1'b1;
      3'd2: w_down = 1'b1;
      3'd3: w_left = 1'b1;
      3'd4: w_right = 1'b1;
      3'd5: begin w_up = 1'b1;   w_right = 1'b1; end
      3'd6: begin w_down = 1'b1; w_right = 1'b1; end
      3'd7: begin w_down = 1'b1; w_left = 1'b1;  end
      default: ;
    endcase

    // Far-edge clamp limits; an oversize platform pins to 0 instead of going negative.
    w_lim_x = (11'(SCREEN_W) > {1'b0, w}) ? 11'(SCREEN_W) - {1'b0, w} : '0;
    w_lim_y = (11'(SCREEN_H) > {1'b0, h}) ? 11'(SCREEN_H) - {1'b0, h} : '0;
    w_sum_x = {1'b0, pos_x} + {6'b0, r_speed};
    w_sum_y = {1'b0, pos_y} + {6'b0, r_speed};

    w_nx    = pos_x;
    w_ny    = pos_y;
    w_hit_x = 1'b0;
    w_hit_y = 1'b0;
    if (r_speed != '0) begin
      if (w_right) begin
        if (w_sum_x >= w_lim_x) begin
          w_nx    = w_lim_x[9:0];
          w_hit_x = 1'b1;
        end else begin
          w_nx = w_sum_x[9:0];
        end
      end else if (w_left) begin
        if ({1'b0, pos_x} <= {6'b0, r_speed}) begin
          w_nx    = '0;
          w_hit_x = 1'b1;
        end else begin
          w_nx = pos_x - {5'b0, r_speed};
        end
      end
      if (w_down) begin
        if (w_sum_y >= w_lim_y) begin
          w_ny    = w_lim_y[9:0];
          w_hit_y = 1'b1;
        end else begin
          w_ny = w_sum_y[9:0];
        end
      end else if (w_up) begin
        if ({1'b0, pos_y} <= {6'b0, r_speed}) begin
          w_ny    = '0;
          w_hit_y = 1'b1;
        end else begin
          w_ny = pos_y - {5'b0, r_speed};
        end
      end
    end

    // Contact flag is registered: the time_tick in the contact cycle itself does not count.
    w_timed_en     = (r_trig == 2'd1) || ((r_trig == 2'd3) && r_contact);
    w_time_destroy = w_timed_en && time_tick && (r_count == '0);
    w_bnd_destroy  = (r_trig == 2'd2) && move_tick && (w_hit_x || w_hit_y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                  <= S_IDLE;
      r_dir                    <= '0;
      r_speed                  <= '0;
      r_x_in                   <= '0;
      r_y_in                   <= '0;
      r_w_in                   <= '0;
      r_h_in                   <= '0;
      r_trig                   <= '0;
      r_count                  <= '0;
      r_contact                <= 1'b0;
      update_platform_position <= 1'b0;
      active                   <= 1'b0;
      pos_x                    <= '0;
      pos_y                    <= '0;
      w                        <= '0;
      h                        <= '0;
      destroyed                <= 1'b0;
    end else begin
      update_platform_position <= 1'b0;
      destroyed                <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!sync_platform_position) begin
            r_state <= S_LOAD;
            active  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_dir                    <= movement_direction;
          r_speed                  <= speed;
          r_x_in                   <= pos_x_in;
          r_y_in                   <= pos_y_in;
          r_w_in                   <= w_in;
          r_h_in                   <= h_in;
          r_trig                   <= destroy_trigger;
          r_count                  <= destroy_time;
          r_contact                <= 1'b0;
          update_platform_position <= 1'b1;
          r_state                  <= S_ACK;
        end
        S_ACK: r_state <= S_RELEASE;
        S_RELEASE: begin
          if (sync_platform_position) begin
            pos_x   <= r_x_in;
            pos_y   <= r_y_in;
            w       <= r_w_in;
            h       <= r_h_in;
            active  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!sync_platform_position) begin
            // A new load pre-empts any move or destroy in this cycle.
            r_state <= S_LOAD;
            active  <= 1'b0;
          end else begin
            if ((r_trig == 2'd3) && player_contact) r_contact <= 1'b1;
            if (w_timed_en && time_tick && (r_count != '0)) r_count <= r_count - 8'd1;
            // A timed destroy freezes position; a boundary destroy still writes the clamp.
            if (move_tick && !w_time_destroy) begin
              pos_x <= w_nx;
              pos_y <= w_ny;
            end
            if (w_time_destroy || w_bnd_destroy) begin
              active    <= 1'b0;
              destroyed <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_motion_controller.sv
module tb_platform_motion_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sync_platform_position = 1'b1;
  logic [2:0] movement_direction = '0;
  logic [4:0] speed = '0;
  logic [9:0] pos_x_in = '0, pos_y_in = '0, w_in = '0, h_in = '0;
  logic [7:0] destroy_time = '0;
  logic [1:0] destroy_trigger = '0;
  logic       move_tick = 1'b0, time_tick = 1'b0, player_contact = 1'b0;
  logic       update_platform_position, active, destroyed;
  logic [9:0] pos_x, pos_y, w, h;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_x, m_y, m_w, m_h, m_dir, m_spd, m_trig, m_cnt;
  bit m_contact, m_running, m_active, m_destroyed;

  always #5 clk = ~clk;

  platform_motion_controller #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .reset(reset),
    .sync_platform_position(sync_platform_position),
    .movement_direction(movement_direction), .speed(speed),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .w_in(w_in), .h_in(h_in),
    .destroy_time(destroy_time), .destroy_trigger(destroy_trigger),
    .move_tick(move_tick), .time_tick(time_tick), .player_contact(player_contact),
    .update_platform_position(update_platform_position), .active(active),
    .pos_x(pos_x), .pos_y(pos_y), .w(w), .h(h), .destroyed(destroyed)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of the behavioural model, evaluated from the game rules.
  task automatic model_cycle(input bit mt, input bit tt, input bit pc);
    int dx, dy, nx, ny, lim;
    bit hit, timed;
    int dxt[8] = '{0, 0, 0, -1, 1, 1, 1, -1};
    int dyt[8] = '{0, -1, 1, 0, 0, -1, 1, 1};
    m_destroyed = 0;
    if (!m_running) return;
    timed = (m_trig == 1) || (m_trig == 3 && m_contact);
    if (m_trig == 3 && pc) m_contact = 1;
    if (timed && tt && m_cnt == 0) begin
      m_running = 0; m_active = 0; m_destroyed = 1;
      return;
    end
    if (timed && tt) m_cnt = m_cnt - 1;
    if (mt && m_spd != 0) begin
      dx = dxt[m_dir]; dy = dyt[m_dir]; hit = 0;
      nx = m_x; ny = m_y;
      if (dx > 0) begin
        lim = 640 - m_w; if (lim < 0) lim = 0;
        nx = m_x + m_spd; if (nx >= lim) begin nx = lim; hit = 1; end
      end else if (dx < 0) begin
        nx = m_x - m_spd; if (nx <= 0) begin nx = 0; hit = 1; end
      end
      if (dy > 0) begin
        lim = 480 - m_h; if (lim < 0) lim = 0;
        ny = m_y + m_spd; if (ny >= lim) begin ny = lim; hit = 1; end
      end else if (dy < 0) begin
        ny = m_y - m_spd; if (ny <= 0) begin ny = 0; hit = 1; end
      end
      m_x = nx; m_y = ny;
      if (m_trig == 2 && hit) begin
        m_running = 0; m_active = 0; m_destroyed = 1;
      end
    end
  endtask

  // Full handshake; hold >= 3 so that active follows the sync rise by one cycle.
  task automatic do_load(input int dir, input int spd, input int x, input int y,
                         input int ww, input int hh, input int dt, input int trig,
                         input int hold);
    int acks;
    movement_direction = 3'(dir); speed = 5'(spd);
    pos_x_in = 10'(x); pos_y_in = 10'(y); w_in = 10'(ww); h_in = 10'(hh);
    destroy_time = 8'(dt); destroy_trigger = 2'(trig);
    sync_platform_position = 1'b0;
    acks = 0;
    for (int i = 1; i <= hold; i++) begin
      step();
      n_vec++;
      if (update_platform_position !== (i == 2)) begin
        n_err++;
        $display("FAIL ack_timing cycle %0d: got %b want %b", i, update_platform_position, (i == 2));
      end
      if (update_platform_position) acks++;
      n_vec++;
      if (active !== 1'b0) begin
        n_err++;
        $display("FAIL active_during_load cycle %0d: got %b want 0", i, active);
      end
    end
    n_vec++;
    if (acks != 1) begin
      n_err++;
      $display("FAIL ack_count: got %0d want 1", acks);
    end
    sync_platform_position = 1'b1;
    step();
    n_vec++;
    if (active !== 1'b1 || pos_x !== 10'(x) || pos_y !== 10'(y) || w !== 10'(ww) || h !== 10'(hh)) begin
      n_err++;
      $display("FAIL load_geometry: got a=%b x=%0d y=%0d w=%0d h=%0d want a=1 x=%0d y=%0d w=%0d h=%0d",
               active, pos_x, pos_y, w, h, x, y, ww, hh);
    end
    m_x = x; m_y = y; m_w = ww; m_h = hh; m_dir = dir; m_spd = spd;
    m_trig = trig; m_cnt = dt; m_contact = 0; m_running = 1; m_active = 1; m_destroyed = 0;
  endtask

  // Apply one cycle of ticks, advance model and DUT, compare everything.
  task automatic run_cycle(input bit mt, input bit tt, input bit pc, input string tag);
    move_tick = mt; time_tick = tt; player_contact = pc;
    model_cycle(mt, tt, pc);
    step();
    move_tick = 0; time_tick = 0; player_contact = 0;
    n_vec++;
    if (active !== m_active || destroyed !== m_destroyed ||
        pos_x !== 10'(m_x) || pos_y !== 10'(m_y)) begin
      n_err++;
      $display("FAIL %s: got a=%b d=%b x=%0d y=%0d want a=%b d=%b x=%0d y=%0d",
               tag, active, destroyed, pos_x, pos_y, m_active, m_destroyed, m_x, m_y);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_vec++;
    if ({update_platform_position, active, destroyed, pos_x, pos_y, w, h} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b a=%b d=%b x=%0d y=%0d w=%0d h=%0d want all 0",
               update_platform_position, active, destroyed, pos_x, pos_y, w, h);
    end
    m_running = 0; m_active = 0; m_destroyed = 0;
  endtask

  task automatic test_load_handshake();
    do_load(4, 3, 100, 200, 64, 8, 0, 0, 5);
  endtask

  task automatic test_movement();
    for (int i = 0; i < 10; i++) run_cycle(1, 0, 0, "move_right");
    n_vec++;
    if (pos_x !== 10'd130 || pos_y !== 10'd200) begin
      n_err++;
      $display("FAIL move_right_final: got (%0d,%0d) want (130,200)", pos_x, pos_y);
    end
    do_load(5, 2, 0, 1, 64, 8, 0, 0, 3);
    for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, "move_upright");
    n_vec++;
    if (pos_x !== 10'd6 || pos_y !== 10'd0) begin
      n_err++;
      $display("FAIL upright_clamp: got (%0d,%0d) want (6,0)", pos_x, pos_y);
    end
  endtask

  task automatic test_boundary_destroy();
    do_load(4, 31, 560, 50, 64, 8, 0, 2, 4);
    run_cycle(1, 0, 0, "boundary_hit");
    n_vec++;
    if (pos_x !== 10'd576 || destroyed !== 1'b1 || active !== 1'b0) begin
      n_err++;
      $display("FAIL boundary_destroy: got x=%0d d=%b a=%b want x=576 d=1 a=0", pos_x, destroyed, active);
    end
    run_cycle(1, 1, 0, "boundary_after");
  endtask

  task automatic test_timed_destroy();
    do_load(0, 0, 10, 10, 20, 20, 3, 1, 3);
    for (int i = 1; i <= 4; i++) begin
      run_cycle(0, 1, 0, "timed3");
      n_vec++;
      if (destroyed !== (i == 4)) begin
        n_err++;
        $display("FAIL timed3_tick%0d: got d=%b want %b", i, destroyed, (i == 4));
      end
      run_cycle(0, 0, 0, "timed3_gap");
    end
    do_load(0, 0, 10, 10, 20, 20, 0, 1, 3);
    run_cycle(0, 1, 0, "timed0");
    n_vec++;
    if (destroyed !== 1'b1 || active !== 1'b0) begin
      n_err++;
      $display("FAIL timed0_first_tick: got d=%b a=%b want d=1 a=0", destroyed, active);
    end
  endtask

  task automatic test_contact_trigger();
    do_load(0, 0, 30, 30, 16, 16, 2, 3, 3);
    for (int i = 0; i < 5; i++) run_cycle(0, 1, 0, "contact_none");
    n_vec++;
    if (active !== 1'b1) begin
      n_err++;
      $display("FAIL contact_precontact_alive: got a=%b want 1", active);
    end
    run_cycle(0, 0, 1, "contact_pulse");
    for (int i = 1; i <= 3; i++) begin
      run_cycle(0, 1, 0, "contact_timed");
      n_vec++;
      if (destroyed !== (i == 3)) begin
        n_err++;
        $display("FAIL contact_tick%0d: got d=%b want %b", i, destroyed, (i == 3));
      end
    end
  endtask

  task automatic test_override_and_reset();
    int acks;
    do_load(0, 0, 40, 40, 16, 16, 0, 1, 3);
    // New load request coincides with a destroying time_tick.
    movement_direction = 3'd2; speed = 5'd4;
    pos_x_in = 10'd300; pos_y_in = 10'd100; w_in = 10'd32; h_in = 10'd32;
    destroy_time = 8'd0; destroy_trigger = 2'd0;
    sync_platform_position = 1'b0; time_tick = 1'b1;
    step();
    time_tick = 1'b0;
    n_vec++;
    if (destroyed !== 1'b0 || active !== 1'b0) begin
      n_err++;
      $display("FAIL override_no_destroy: got d=%b a=%b want d=0 a=0", destroyed, active);
    end
    step();
    n_vec++;
    if (update_platform_position !== 1'b1) begin
      n_err++;
      $display("FAIL override_ack: got %b want 1", update_platform_position);
    end
    step();
    sync_platform_position = 1'b1;
    step();
    n_vec++;
    if (active !== 1'b1 || pos_x !== 10'd300 || pos_y !== 10'd100 || w !== 10'd32) begin
      n_err++;
      $display("FAIL override_new_desc: got a=%b x=%0d y=%0d w=%0d want a=1 x=300 y=100 w=32",
               active, pos_x, pos_y, w);
    end
    // Reset during RELEASE.
    sync_platform_position = 1'b0;
    step(); step(); step(); step();
    reset = 1'b1; sync_platform_position = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if ({update_platform_position, active, destroyed, pos_x, pos_y, w, h} !== '0) begin
      n_err++;
      $display("FAIL reset_in_release: got ack=%b a=%b x=%0d y=%0d w=%0d h=%0d want all 0",
               update_platform_position, active, pos_x, pos_y, w, h);
    end
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (update_platform_position || active) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL reset_no_ack_after: got %0d ack/active cycles want 0", acks);
    end
    m_running = 0; m_active = 0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      do_load($urandom_range(7), $urandom_range(31), $urandom_range(639), $urandom_range(479),
              $urandom_range(200, 1), $urandom_range(200, 1), $urandom_range(5),
              $urandom_range(3), $urandom_range(6, 3));
      for (int c = 0; c < 60; c++)
        run_cycle($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_load_handshake();
    test_movement();
    test_boundary_destroy();
    test_timed_destroy();
    test_contact_trigger();
    test_override_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
